// File: rtl/lsu_dmem_ctrl_if.sv
// Request/response and ram-side bundle for lsu_dmem_ctrl.
// slave  : the controller's view (receives requests, drives the ram).
// master : the environment's view (issues requests, models the ram).
//
// Handshake: a request transfers on the rising edge where req_valid_i and
// req_ready_o are both high. req_ready_o is high only while the controller is
// idle, so at most one request is outstanding. The requester must keep its
// fields stable while req_valid_i is high and not yet accepted. resp_valid_o is
// a single-cycle pulse with no backpressure; resp_rdata_o and resp_error_o are
// meaningful only while it is high.
interface lsu_dmem_ctrl_if #(
  parameter int ADDR_WIDTH = 64
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_we_i;
  logic [1:0]            req_size_i;
  logic                  req_unsigned_i;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [63:0]           req_wdata_i;

  logic                  resp_valid_o;
  logic [63:0]           resp_rdata_o;
  logic                  resp_error_o;

  logic                  ram_read_en_o;
  logic                  ram_write_en_o;
  logic [ADDR_WIDTH-1:0] ram_addr_o;
  logic [63:0]           ram_write_data_o;
  logic [63:0]           ram_read_data_i;
  logic                  ram_error_i;

  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i,
           req_wdata_i, ram_read_data_i, ram_error_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_error_o,
           ram_read_en_o, ram_write_en_o, ram_addr_o, ram_write_data_o
  );

  modport master (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i,
           req_wdata_i, ram_read_data_i, ram_error_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_error_o,
           ram_read_en_o, ram_write_en_o, ram_addr_o, ram_write_data_o
  );
endinterface

// File: rtl/lsu_dmem_ctrl.sv
// Load/store controller in front of a 64-bit little-endian data ram.
// One request at a time; sub-doubleword stores are read-modify-write,
// loads are extracted and sign/zero extended, bad accesses return an error.
// Optional macro LSU_PERF_CNT_EN adds load/store/error event counters.
module lsu_dmem_ctrl #(
  parameter int ADDR_WIDTH = 64,
  parameter int MEM_BYTES  = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  lsu_dmem_ctrl_if.slave        bus,
  output logic [2:0]            state_o
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [31:0]           load_cnt_o,
  output logic [31:0]           store_cnt_o,
  output logic [31:0]           err_cnt_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_WR   = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t state;
  state_t state_next;

  // Latched request
  logic                  we_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [2:0]            off_q;
  logic [63:0]           wdata_q;
  logic                  err_q;
  logic [63:0]           resp_rdata_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [63:0]           ram_wdata_q;

  // Request qualification
  logic                  accept;
  logic [2:0]            off_in;
  logic [3:0]            nbytes_in;
  logic [ADDR_WIDTH:0]   last_byte;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  bad_req;

  // Load extraction / store merge
  logic [63:0]           shifted;
  logic [63:0]           load_ext;
  logic [7:0]            byte_mask;
  logic [63:0]           bit_mask;
  logic [63:0]           wdata_shifted;
  logic [63:0]           merged;

  assign accept = bus.req_valid_i && (state == S_IDLE);

  // Classify the incoming request: alignment and range of its last byte.
  // The sum is one bit wider than the address so a wrap near the top of
  // the address space still counts as out of range.
  always_comb begin
    off_in    = bus.req_addr_i[2:0];
    nbytes_in = 4'd1 << bus.req_size_i;
    unique case (bus.req_size_i)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = off_in[0];
      2'd2:    misaligned = |off_in[1:0];
      default: misaligned = |off_in;
    endcase
    last_byte    = {1'b0, bus.req_addr_i} + (ADDR_WIDTH+1)'(nbytes_in)
                   - (ADDR_WIDTH+1)'(1);
    out_of_range = last_byte >= (ADDR_WIDTH+1)'(MEM_BYTES);
    bad_req      = misaligned || out_of_range;
  end

  // Extract load data from the ram word and build the RMW merge word.
  always_comb begin
    shifted = bus.ram_read_data_i >> {off_q, 3'b000};
    unique case (size_q)
      2'd0:    load_ext = uns_q ? {56'd0, shifted[7:0]}
                                : {{56{shifted[7]}}, shifted[7:0]};
      2'd1:    load_ext = uns_q ? {48'd0, shifted[15:0]}
                                : {{48{shifted[15]}}, shifted[15:0]};
      2'd2:    load_ext = uns_q ? {32'd0, shifted[31:0]}
                                : {{32{shifted[31]}}, shifted[31:0]};
      default: load_ext = shifted;
    endcase

    unique case (size_q)
      2'd0:    byte_mask = 8'h01 << off_q;
      2'd1:    byte_mask = 8'h03 << off_q;
      2'd2:    byte_mask = 8'h0f << off_q;
      default: byte_mask = 8'hff;
    endcase
    bit_mask = '0;
    for (int i = 0; i < 8; i++) begin
      bit_mask[i*8 +: 8] = {8{byte_mask[i]}};
    end
    wdata_shifted = wdata_q << {off_q, 3'b000};
    merged        = (bus.ram_read_data_i & ~bit_mask) | (wdata_shifted & bit_mask);
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic; a ram error in any ram-access state ends the op.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          if (bad_req)                                  state_next = S_RESP;
          else if (bus.req_we_i && bus.req_size_i == 2'd3) state_next = S_WR;
          else                                          state_next = S_RD;
        end
      end
      S_RD:    state_next = bus.ram_error_i ? S_RESP : S_CAP;
      S_CAP: begin
        if (bus.ram_error_i) state_next = S_RESP;
        else if (we_q)       state_next = S_WR;
        else                 state_next = S_RESP;
      end
      S_WR:    state_next = S_RESP;
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state plus the registered datapath values.
  always_comb begin
    bus.req_ready_o      = (state == S_IDLE);
    bus.resp_valid_o     = (state == S_RESP);
    bus.resp_error_o     = (state == S_RESP) && err_q;
    bus.resp_rdata_o     = resp_rdata_q;
    bus.ram_read_en_o    = (state == S_RD) || (state == S_CAP);
    bus.ram_write_en_o   = (state == S_WR);
    bus.ram_addr_o       = ram_addr_q;
    bus.ram_write_data_o = ram_wdata_q;
    state_o              = state;
  end

  // Request latch, error tracking, load capture and store data staging.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_q         <= 1'b0;
      size_q       <= 2'd0;
      uns_q        <= 1'b0;
      off_q        <= 3'd0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
      resp_rdata_q <= '0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            we_q         <= bus.req_we_i;
            size_q       <= bus.req_size_i;
            uns_q        <= bus.req_unsigned_i;
            off_q        <= off_in;
            wdata_q      <= bus.req_wdata_i;
            err_q        <= bad_req;
            resp_rdata_q <= '0;
            // A rejected request never touches the ram, so the ram
            // address keeps its previous value.
            if (!bad_req) begin
              ram_addr_q <= {bus.req_addr_i[ADDR_WIDTH-1:3], 3'b000};
              if (bus.req_we_i && bus.req_size_i == 2'd3) begin
                ram_wdata_q <= bus.req_wdata_i;
              end
            end
          end
        end
        S_RD: begin
          if (bus.ram_error_i) err_q <= 1'b1;
        end
        S_CAP: begin
          if (bus.ram_error_i) err_q <= 1'b1;
          else if (we_q)       ram_wdata_q  <= merged;
          else                 resp_rdata_q <= load_ext;
        end
        S_WR: begin
          if (bus.ram_error_i) err_q <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef LSU_PERF_CNT_EN
  // Event counters, one update per completed response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      load_cnt_o  <= '0;
      store_cnt_o <= '0;
      err_cnt_o   <= '0;
    end else if (state == S_RESP) begin
      if (err_q)     err_cnt_o   <= err_cnt_o + 32'd1;
      else if (we_q) store_cnt_o <= store_cnt_o + 32'd1;
      else           load_cnt_o  <= load_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: doc/lsu_dmem_ctrl.md
Name: lsu_dmem_ctrl

Overview:
Load/store controller directly upstream of the data memory `ram` (64-bit doubleword-wide, little-endian) in the CPU memory stage. It accepts one byte/half/word/double load or store request at a time and issues doubleword-aligned ram accesses. Sub-doubleword stores are done as read-modify-write. Load data is extracted and sign- or zero-extended. Misaligned, out-of-range and ram-flagged accesses return an error response.

Parameters:
ADDR_WIDTH, 64, request/ram address width.
MEM_BYTES, 256, ram size in bytes; any access whose last byte is at or above MEM_BYTES is out of range.

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-high
req_valid_i  in  1  request present
req_ready_o  out  1  controller can accept; high only in IDLE
req_we_i  in  1  1=store, 0=load
req_size_i  in  2  0=byte, 1=half, 2=word, 3=double
req_unsigned_i  in  1  load zero-extends when 1
req_addr_i  in  ADDR_WIDTH  byte address
req_wdata_i  in  64  store data, right-justified
resp_valid_o  out  1  one-cycle completion pulse
resp_rdata_o  out  64  extended load data; 0 for stores/errors
resp_error_o  out  1  error flag, valid with resp_valid_o
ram_read_en_o  out  1  to ram read_en
ram_write_en_o  out  1  to ram write_en
ram_addr_o  out  ADDR_WIDTH  to ram addr_i, always addr with [2:0]=0
ram_write_data_o  out  64  to ram write_data_i
ram_read_data_i  in  64  from ram read_data_o
ram_error_i  in  1  from ram dmem_error_o

Behaviour:
- Reset: state IDLE, req_ready_o=1, resp_valid_o=0, resp_rdata_o=0, resp_error_o=0, ram enables=0, ram_addr_o=0, ram_write_data_o=0.
- Accept on the rising edge where req_valid_i&&req_ready_o. Latch we, size, unsigned, addr, wdata. The edge where the request is accepted is cycle 0.
- Off = addr[2:0]. Misaligned when off is not a multiple of (1<<size). Misaligned or out of range: IDLE->RESP, error=1, no ram enable ever asserted. resp_valid_o is high in cycle 1.
- Load: IDLE->RD->CAP->RESP.
  - RD: ram_read_en_o=1.
  - CAP: ram_read_en_o=1, address held; read data registered at the end of CAP.
  - RESP: resp_valid_o=1 in cycle 3. Data = (ram data >> off*8), truncated to size, then sign-extended (or zero-extended if req_unsigned_i). Double ignores req_unsigned_i.
- Double store: IDLE->WR->RESP. WR has ram_write_en_o=1 and data=wdata. resp_valid_o=1 in cycle 2.
- Sub-doubleword store: IDLE->RD->CAP->WR->RESP. In WR, the selected byte lanes [off .. off+(1<<size)-1] are replaced with the low bytes of wdata; other lanes keep the captured ram data. resp_valid_o=1 in cycle 4.
- ram_error_i is sampled in RD, CAP and WR. If high, go to RESP with error=1 and rdata=0; no later ram access is made (the RMW write is skipped).
- ram_read_en_o and ram_write_en_o are never high together. Both are 0 in IDLE and RESP. ram_addr_o holds its last value when idle.
- RESP->IDLE unconditionally. There is no response backpressure. A new request can be accepted in the cycle after RESP.
- rst_i high in any state, including mid-RMW: next state IDLE, enables drop, the pending op is discarded with no response and no ram write.

Optional Feature:
LSU_PERF_CNT_EN:
- Defined: adds 32-bit outputs load_cnt_o, store_cnt_o and err_cnt_o.
  - load_cnt_o / store_cnt_o increment on each error-free RESP of that type.
  - err_cnt_o increments on each error RESP.
  - All counters wrap at 2^32 and are cleared by rst_i.
- Undefined: these ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
1. Store D 0x1122334455667788 @0x10 -> ram_write_en_o in cycle 1 with addr 0x10, resp in cycle 2. Then load D @0x10 -> resp_rdata_o=0x1122334455667788 in cycle 3, error=0.
2. With 0x0 at 0x10, store B 0xAB @0x13 -> WR data 0x00000000AB000000, resp in cycle 4. Load B signed @0x13 -> 0xFFFFFFFFFFFFFFAB. Load B unsigned -> 0x00000000000000AB.
3. Load W @0x22 -> resp in cycle 1 with error=1, rdata=0, ram enables never asserted. Load H @0x100 (MEM_BYTES=256) -> same.
4. Store H 0xBEEF @0x16 with ram_error_i forced high in RD -> error=1 and ram_write_en_o never asserts.
5. rst_i pulsed during CAP of store B @0x08 -> no ram_write_en_o, no resp_valid_o, req_ready_o=1 the cycle after reset releases, ram content at 0x08 unchanged.
6. Back-to-back load D @0x00 then @0x08, req_valid_i held high -> second accept the cycle after the first RESP, responses at cycles 3 and 7.
